// File: rtl/smi_arb_pkg.sv
// Shared types for the two-port SMI frame arbiter: FSM states, grant encodings, Eofc width.
package smi_arb_pkg;

    localparam int SMI_EOFC_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_A,
        GRANT_B
    } state_t;

    localparam logic [1:0] ACT_NONE = 2'b00;
    localparam logic [1:0] ACT_A    = 2'b01;
    localparam logic [1:0] ACT_B    = 2'b10;

endpackage

// File: rtl/smi_skid_buffer.sv
// Two-entry skid buffer, 1-cycle latency; upstream stop comes straight from a register, so a
// downstream stop is absorbed with at most one extra accepted flit and never reaches up_stop combinationally.
module smi_skid_buffer #(
    parameter int Width = 40
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             up_vld,
    input  logic [Width-1:0] up_dat,
    output logic             up_stop,
    output logic             dn_vld,
    output logic [Width-1:0] dn_dat,
    input  logic             dn_stop
);

    logic [Width-1:0] head_q;
    logic [Width-1:0] tail_q;
    logic             head_vld_q;
    logic             tail_vld_q;
    logic             push;
    logic             pop;

    // The tail entry only fills when the head is stalled, so "tail occupied" is exactly "full".
    assign up_stop = tail_vld_q;
    assign push    = up_vld && !tail_vld_q;
    assign pop     = head_vld_q && !dn_stop;
    assign dn_vld  = head_vld_q;
    assign dn_dat  = head_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else if (pop) begin
            if (tail_vld_q) begin
                head_q     <= tail_q;
                tail_vld_q <= 1'b0;
            end else begin
                head_vld_q <= push;
                if (push) begin
                    head_q <= up_dat;
                end
            end
        end else if (push) begin
            if (head_vld_q) begin
                tail_q     <= up_dat;
                tail_vld_q <= 1'b1;
            end else begin
                head_q     <= up_dat;
                head_vld_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/smi_flit_frame_arbiter.sv
// Frame-granular round-robin arbiter of two SMI flit streams onto one; 1-cycle grant, 1-cycle data
// latency through the output skid buffer, one idle bubble per frame; the ungranted port is always stopped.
module smi_flit_frame_arbiter
    import smi_arb_pkg::*;
#(
    parameter int FlitWidth  = 4,
    parameter int CountWidth = 16
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    smiInAReady,
    input  logic [SMI_EOFC_W-1:0]   smiInAEofc,
    input  logic [FlitWidth*8-1:0]  smiInAData,
    output logic                    smiInAStop,
    input  logic                    smiInBReady,
    input  logic [SMI_EOFC_W-1:0]   smiInBEofc,
    input  logic [FlitWidth*8-1:0]  smiInBData,
    output logic                    smiInBStop,
    output logic                    smiOutReady,
    output logic [SMI_EOFC_W-1:0]   smiOutEofc,
    output logic [FlitWidth*8-1:0]  smiOutData,
    input  logic                    smiOutStop,
    output logic [CountWidth-1:0]   frameCountA,
    output logic [CountWidth-1:0]   frameCountB,
    output logic [1:0]              activePort
);

    localparam int DataW = FlitWidth * 8;
    localparam int VecW  = DataW + SMI_EOFC_W;

    state_t          state_q;
    state_t          state_d;
    logic            last_b_q;
    logic            mux_vld;
    logic [VecW-1:0] mux_dat;
    logic            skid_stop;
    logic [VecW-1:0] out_vec;
    logic            frame_end;

    always_comb begin
        mux_vld    = 1'b0;
        mux_dat    = '0;
        smiInAStop = 1'b1;
        smiInBStop = 1'b1;
        activePort = ACT_NONE;
        case (state_q)
            GRANT_A: begin
                mux_vld    = smiInAReady;
                mux_dat    = {smiInAEofc, smiInAData};
                smiInAStop = skid_stop;
                activePort = ACT_A;
            end
            GRANT_B: begin
                mux_vld    = smiInBReady;
                mux_dat    = {smiInBEofc, smiInBData};
                smiInBStop = skid_stop;
                activePort = ACT_B;
            end
            default: ;
        endcase
    end

    // Only zero vs nonzero Eofc matters here; the value itself passes through untouched.
    assign frame_end = mux_vld && !skid_stop && (mux_dat[DataW +: SMI_EOFC_W] != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (smiInAReady && smiInBReady) begin
                    state_d = last_b_q ? GRANT_A : GRANT_B;
                end else if (smiInAReady) begin
                    state_d = GRANT_A;
                end else if (smiInBReady) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            frameCountA <= '0;
            frameCountB <= '0;
        end else begin
            state_q <= state_d;
            if (frame_end) begin
                last_b_q <= (state_q == GRANT_B);
                if (state_q == GRANT_A && frameCountA != {CountWidth{1'b1}}) begin
                    frameCountA <= frameCountA + 1'b1;
                end
                if (state_q == GRANT_B && frameCountB != {CountWidth{1'b1}}) begin
                    frameCountB <= frameCountB + 1'b1;
                end
            end
        end
    end

    smi_skid_buffer #(
        .Width (VecW)
    ) u_out_skid (
        .clk     (clk),
        .arstn   (arstn),
        .up_vld  (mux_vld),
        .up_dat  (mux_dat),
        .up_stop (skid_stop),
        .dn_vld  (smiOutReady),
        .dn_dat  (out_vec),
        .dn_stop (smiOutStop)
    );

    assign smiOutEofc = out_vec[DataW +: SMI_EOFC_W];
    assign smiOutData = out_vec[DataW-1:0];

endmodule

// File: tb/tb_smi_flit_frame_arbiter.sv
// Directed bench for smi_flit_frame_arbiter: per-cycle vector table plus scripted frame sequences.
module tb_smi_flit_frame_arbiter;

    logic        clk = 1'b0;
    logic        arstn;
    logic        aRdy, bRdy, aStop, bStop, oRdy, oStop;
    logic [7:0]  aEofc, bEofc, oEofc;
    logic [31:0] aDat, bDat, oDat;
    logic [1:0]  cntA, cntB, act;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    smi_flit_frame_arbiter #(.FlitWidth(4), .CountWidth(2)) dut (
        .clk(clk), .arstn(arstn),
        .smiInAReady(aRdy), .smiInAEofc(aEofc), .smiInAData(aDat), .smiInAStop(aStop),
        .smiInBReady(bRdy), .smiInBEofc(bEofc), .smiInBData(bDat), .smiInBStop(bStop),
        .smiOutReady(oRdy), .smiOutEofc(oEofc), .smiOutData(oDat), .smiOutStop(oStop),
        .frameCountA(cntA), .frameCountB(cntB), .activePort(act)
    );

    typedef struct packed {
        logic        o_rdy;
        logic [7:0]  o_eofc;
        logic [31:0] o_dat;
        logic        a_stop;
        logic        b_stop;
        logic [1:0]  act;
        logic [1:0]  ca;
        logic [1:0]  cb;
    } exp_t;

    typedef struct {
        logic        a_rdy;
        logic [7:0]  a_eofc;
        logic [31:0] a_dat;
        logic        b_rdy;
        logic [7:0]  b_eofc;
        logic [31:0] b_dat;
        exp_t        exp;
    } vec_t;

    vec_t        vecs[$];
    logic [39:0] got[$];

    function automatic vec_t mk(int ar, int ae, int ad, int br, int be, int bd,
                                int ordy, int oe, int od, int as, int bs, int ac, int ca, int cb);
        vec_t v;
        v.a_rdy      = ar[0];
        v.a_eofc     = ae[7:0];
        v.a_dat      = ad;
        v.b_rdy      = br[0];
        v.b_eofc     = be[7:0];
        v.b_dat      = bd;
        v.exp.o_rdy  = ordy[0];
        v.exp.o_eofc = oe[7:0];
        v.exp.o_dat  = od;
        v.exp.a_stop = as[0];
        v.exp.b_stop = bs[0];
        v.exp.act    = ac[1:0];
        v.exp.ca     = ca[1:0];
        v.exp.cb     = cb[1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
        total++;
        if (actual !== required)
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        else
            passed++;
    endtask

    task automatic idle_inputs();
        aRdy = 1'b0; aEofc = '0; aDat = '0;
        bRdy = 1'b0; bEofc = '0; bDat = '0;
        oStop = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
    endtask

    // Drives one frame on the chosen port, stalls the output over cycles [st_lo, st_hi),
    // collects every output transfer into got[], and optionally resets after abort_at input transfers.
    task automatic run_frame(input bit pb, input int len, input int last, input int base,
                             input int st_lo, input int st_hi, input int abort_at);
        int   idx = 0;
        logic cur_stop, cur_rdy;
        logic other_low = 1'b0;
        got.delete();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            oStop   = (k >= st_lo && k < st_hi);
            cur_rdy = (idx < len);
            aRdy = 1'b0; bRdy = 1'b0;
            if (pb) begin
                bRdy = cur_rdy; bEofc = (idx == len - 1) ? last[7:0] : 8'h00; bDat = base + idx;
            end else begin
                aRdy = cur_rdy; aEofc = (idx == len - 1) ? last[7:0] : 8'h00; aDat = base + idx;
            end
            #1;
            if (abort_at >= 0 && idx == abort_at) begin
                chk("pre_abort_ordy", 64'(oRdy), 64'(1));
                arstn = 1'b0;
                #1;
                chk("abort_ordy", 64'(oRdy), 64'(0));
                break;
            end
            cur_stop = pb ? bStop : aStop;
            if ((pb ? aStop : bStop) == 1'b0) other_low = 1'b1;
            if (st_hi > st_lo && k == st_lo + 1)
                chk("stop_rise", 64'(cur_stop), 64'(1));
            if (oRdy && !oStop) got.push_back({oEofc, oDat});
            @(posedge clk);
            if (cur_rdy && !cur_stop) idx++;
        end
        idle_inputs();
        chk("other_port_stop_low", 64'(other_low), 64'(0));
        if (abort_at < 0) chk("in_xfer_count", 64'(idx), 64'(len));
    endtask

    task automatic chk_frame(input int len, input int last, input int base);
        logic [7:0]  e;
        logic [31:0] d;
        chk("out_flit_count", 64'(got.size()), 64'(len));
        for (int i = 0; i < len && i < got.size(); i++) begin
            e = (i == len - 1) ? last[7:0] : 8'h00;
            d = base + i;
            chk($sformatf("out_flit%0d", i), 64'(got[i]), 64'({e, d}));
        end
    endtask

    initial begin
        exp_t act_v;
        int   sat_exp[5] = '{1, 2, 3, 3, 3};

        // Simultaneous after reset (A wins), then A alone, then simultaneous with lastGrant=A (B wins).
        vecs.push_back(mk(1,0,'h11, 1,0,'h21, 0,0,0,     1,1,0,0,0));
        vecs.push_back(mk(1,0,'h11, 1,0,'h21, 0,0,0,     0,1,1,0,0));
        vecs.push_back(mk(1,2,'h12, 1,0,'h21, 1,0,'h11,  0,1,1,0,0));
        vecs.push_back(mk(0,0,0,    1,0,'h21, 1,2,'h12,  1,1,0,1,0));
        vecs.push_back(mk(0,0,0,    1,0,'h21, 0,0,0,     1,0,2,1,0));
        vecs.push_back(mk(0,0,0,    1,3,'h22, 1,0,'h21,  1,0,2,1,0));
        vecs.push_back(mk(0,0,0,    0,0,0,    1,3,'h22,  1,1,0,1,1));
        vecs.push_back(mk(0,0,0,    0,0,0,    0,0,0,     1,1,0,1,1));
        vecs.push_back(mk(1,0,'hA0, 0,0,0,    0,0,0,     1,1,0,1,1));
        vecs.push_back(mk(1,0,'hA0, 0,0,0,    0,0,0,     0,1,1,1,1));
        vecs.push_back(mk(1,0,'hA1, 0,0,0,    1,0,'hA0,  0,1,1,1,1));
        vecs.push_back(mk(1,0,'hA2, 0,0,0,    1,0,'hA1,  0,1,1,1,1));
        vecs.push_back(mk(1,4,'hA3, 0,0,0,    1,0,'hA2,  0,1,1,1,1));
        vecs.push_back(mk(0,0,0,    0,0,0,    1,4,'hA3,  1,1,0,2,1));
        vecs.push_back(mk(1,0,'h11, 1,0,'h21, 0,0,0,     1,1,0,2,1));
        vecs.push_back(mk(1,0,'h11, 1,0,'h21, 0,0,0,     1,0,2,2,1));
        vecs.push_back(mk(1,0,'h11, 1,3,'h22, 1,0,'h21,  1,0,2,2,1));
        vecs.push_back(mk(1,0,'h11, 0,0,0,    1,3,'h22,  1,1,0,2,2));
        vecs.push_back(mk(1,0,'h11, 0,0,0,    0,0,0,     0,1,1,2,2));
        vecs.push_back(mk(1,2,'h12, 0,0,0,    1,0,'h11,  0,1,1,2,2));
        vecs.push_back(mk(0,0,0,    0,0,0,    1,2,'h12,  1,1,0,3,2));
        vecs.push_back(mk(0,0,0,    0,0,0,    0,0,0,     1,1,0,3,2));

        do_reset();
        #1;
        chk("rst_out_ready", 64'(oRdy), 64'(0));
        chk("rst_out_eofc", 64'(oEofc), 64'(0));
        chk("rst_out_data", 64'(oDat), 64'(0));
        chk("rst_stops", 64'({aStop, bStop}), 64'(2'b11));
        chk("rst_active", 64'(act), 64'(0));
        chk("rst_counts", 64'({cntA, cntB}), 64'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            aRdy = vecs[i].a_rdy; aEofc = vecs[i].a_eofc; aDat = vecs[i].a_dat;
            bRdy = vecs[i].b_rdy; bEofc = vecs[i].b_eofc; bDat = vecs[i].b_dat;
            oStop = 1'b0;
            #1;
            act_v = '{oRdy, oEofc, oDat, aStop, bStop, act, cntA, cntB};
            if (!vecs[i].exp.o_rdy) begin
                act_v.o_eofc = '0;
                act_v.o_dat  = '0;
            end
            chk($sformatf("vec%0d", i), 64'(act_v), 64'(vecs[i].exp));
        end
        idle_inputs();

        do_reset();
        run_frame(1'b1, 6, 6, 'hB0, 5, 8, -1);
        chk_frame(6, 6, 'hB0);
        chk("bp_count_b", 64'(cntB), 64'(1));

        do_reset();
        run_frame(1'b0, 5, 5, 'hC0, 0, 0, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        chk("mid_rst_count_a", 64'(cntA), 64'(0));
        run_frame(1'b0, 1, 1, 'hD0, 0, 0, -1);
        chk_frame(1, 1, 'hD0);
        chk("post_rst_count_a", 64'(cntA), 64'(1));

        do_reset();
        for (int j = 0; j < 5; j++) begin
            run_frame(1'b0, 1, 1, 'hE0 + j, 0, 0, -1);
            chk($sformatf("sat_count_a%0d", j), 64'(cntA), 64'(sat_exp[j]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
